// File: rtl/regfile_pkg.sv
// Shared definitions for the register-file sequencer.
// Contents: opcode constants, rf_dst write-command codes, instruction
// field positions, the sequencer FSM state type and a decode helper.
package regfile_pkg;

  // Opcodes (instr[15:12]); 4..15 are illegal
  localparam logic [3:0] OP_ALU  = 4'd0;
  localparam logic [3:0] OP_MUL  = 4'd1;
  localparam logic [3:0] OP_SWAP = 4'd2;
  localparam logic [3:0] OP_NOP  = 4'd3;

  // rf_dst write commands
  localparam logic [1:0] DST_NONE  = 2'b00;  // no write
  localparam logic [1:0] DST_W1    = 2'b01;  // w1 -> R[add1]
  localparam logic [1:0] DST_W12   = 2'b10;  // w1 -> R[add1], w2 -> R[add2]
  localparam logic [1:0] DST_W1_15 = 2'b11;  // w1 -> R[add1], w15 -> R15

  // Instruction field slice positions
  localparam int INSTR_W = 16;
  localparam int OPC_MSB = 15;
  localparam int OPC_LSB = 12;
  localparam int RA_MSB  = 11;
  localparam int RA_LSB  = 8;
  localparam int RB_MSB  = 7;
  localparam int RB_LSB  = 4;
  localparam int FN_MSB  = 3;
  localparam int FN_LSB  = 0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_READ = 2'd1,
    ST_EXEC = 2'd2,
    ST_WB   = 2'd3
  } state_t;

  // True for opcodes that launch the ALU
  function automatic logic uses_alu(input logic [3:0] opc);
    return (opc == OP_ALU) || (opc == OP_MUL);
  endfunction

endpackage

// File: rtl/regfile_seq_timeout.sv
// EXEC-phase cycle counter for the register-file sequencer.
// Ports:
//   clk      - clock, rising edge
//   rst_n    - asynchronous active-low reset
//   restart  - reload the counter to 1 (held while not executing)
//   en       - count one more EXEC cycle
//   expired  - counter has reached TIMEOUT
// The counter reads 1 during the first EXEC cycle, 2 during the second,
// and so on; it saturates at TIMEOUT.
module regfile_seq_timeout #(
  parameter int TIMEOUT = 15
) (
  input  logic clk,
  input  logic rst_n,
  input  logic restart,
  input  logic en,
  output logic expired
);

  localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

  logic [CNT_W-1:0] cnt_r;
  logic             expired_s;

  // Terminal-count compare
  always_comb begin
    expired_s = (cnt_r == CNT_W'(TIMEOUT));
  end

  assign expired = expired_s;

  // EXEC cycle counter: reload to 1 outside EXEC, saturating increment inside
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r <= CNT_W'(1);
    end else if (restart) begin
      cnt_r <= CNT_W'(1);
    end else if (en && !expired_s) begin
      cnt_r <= cnt_r + CNT_W'(1);
    end else begin
      cnt_r <= cnt_r;
    end
  end

endmodule

// File: rtl/regfile_seq_ctrl.sv
// Multi-cycle sequencer between the instruction source and the 16x16
// register file plus ALU. One instruction per valid/ready handshake:
// IDLE (accept, drive read addresses) -> READ (capture operands) ->
// EXEC (ALU/MUL only, wait for alu_done or timeout) -> WB (one write
// command, done/err pulse) -> IDLE. Every output is registered.
// Ports:
//   CLOCK, CLEAR            - clock / asynchronous active-low reset
//   instr, instr_valid      - instruction input, handshake with instr_ready
//   rf_add1/2, rf_dat1/2    - register-file addresses and read data
//   rf_w1/w2/w15, rf_dst    - write data and write command
//   alu_a/b/func/mul/start  - ALU launch; alu_res/res_hi/done - ALU result
//   done, err, busy         - completion pulse, error pulse, not-idle flag
module regfile_seq_ctrl
  import regfile_pkg::*;
#(
  parameter int DATA_W      = 16,
  parameter int ADDR_W      = 4,
  parameter int ALU_TIMEOUT = 15
) (
  input  logic              CLOCK,
  input  logic              CLEAR,
  input  logic [15:0]       instr,
  input  logic              instr_valid,
  output logic              instr_ready,
  output logic [ADDR_W-1:0] rf_add1,
  output logic [ADDR_W-1:0] rf_add2,
  input  logic [DATA_W-1:0] rf_dat1,
  input  logic [DATA_W-1:0] rf_dat2,
  output logic [DATA_W-1:0] rf_w1,
  output logic [DATA_W-1:0] rf_w2,
  output logic [DATA_W-1:0] rf_w15,
  output logic [1:0]        rf_dst,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [3:0]        alu_func,
  output logic              alu_mul,
  output logic              alu_start,
  input  logic [DATA_W-1:0] alu_res,
  input  logic [DATA_W-1:0] alu_res_hi,
  input  logic              alu_done,
  output logic              done,
  output logic              err,
  output logic              busy
);

  state_t state_r, state_s;
  logic [3:0]        opc_r, opc_s;
  logic [3:0]        func_r, func_s;
  logic              instr_ready_r, instr_ready_s;
  logic [ADDR_W-1:0] rf_add1_r, rf_add1_s;
  logic [ADDR_W-1:0] rf_add2_r, rf_add2_s;
  logic [DATA_W-1:0] rf_w1_r, rf_w1_s;
  logic [DATA_W-1:0] rf_w2_r, rf_w2_s;
  logic [DATA_W-1:0] rf_w15_r, rf_w15_s;
  logic [1:0]        rf_dst_r, rf_dst_s;
  logic [DATA_W-1:0] alu_a_r, alu_a_s;
  logic [DATA_W-1:0] alu_b_r, alu_b_s;
  logic [3:0]        alu_func_r, alu_func_s;
  logic              alu_mul_r, alu_mul_s;
  logic              alu_start_r, alu_start_s;
  logic              done_r, done_s;
  logic              err_r, err_s;
  logic              busy_r, busy_s;
  logic              tmo_expired_s;

  regfile_seq_timeout #(
    .TIMEOUT (ALU_TIMEOUT)
  ) u_timeout (
    .clk     (CLOCK),
    .rst_n   (CLEAR),
    .restart (state_r != ST_EXEC),
    .en      (state_r == ST_EXEC),
    .expired (tmo_expired_s)
  );

  // Next-state and next-output logic; pulses default low, data holds
  always_comb begin
    state_s     = state_r;
    opc_s       = opc_r;
    func_s      = func_r;
    rf_add1_s   = rf_add1_r;
    rf_add2_s   = rf_add2_r;
    rf_w1_s     = rf_w1_r;
    rf_w2_s     = rf_w2_r;
    rf_w15_s    = rf_w15_r;
    rf_dst_s    = DST_NONE;
    alu_a_s     = alu_a_r;
    alu_b_s     = alu_b_r;
    alu_func_s  = alu_func_r;
    alu_mul_s   = alu_mul_r;
    alu_start_s = 1'b0;
    done_s      = 1'b0;
    err_s       = 1'b0;

    case (state_r)
      ST_IDLE: begin
        if (instr_valid) begin
          opc_s     = instr[OPC_MSB:OPC_LSB];
          func_s    = instr[FN_MSB:FN_LSB];
          rf_add1_s = instr[RA_MSB:RA_LSB];
          rf_add2_s = instr[RB_MSB:RB_LSB];
          state_s   = ST_READ;
        end else begin
          state_s   = ST_IDLE;
        end
      end

      ST_READ: begin
        alu_a_s = rf_dat1;
        alu_b_s = rf_dat2;
        if (uses_alu(opc_r)) begin
          // alu_start is registered, so it is high in the first EXEC cycle
          alu_func_s  = func_r;
          alu_mul_s   = (opc_r == OP_MUL);
          alu_start_s = 1'b1;
          state_s     = ST_EXEC;
        end else begin
          done_s  = 1'b1;
          state_s = ST_WB;
          case (opc_r)
            OP_SWAP: begin
              rf_w1_s  = rf_dat2;
              rf_w2_s  = rf_dat1;
              rf_dst_s = DST_W12;
            end
            OP_NOP: begin
              rf_dst_s = DST_NONE;
            end
            default: begin
              err_s = 1'b1;
            end
          endcase
        end
      end

      ST_EXEC: begin
        if (alu_done) begin
          rf_w1_s = alu_res;
          done_s  = 1'b1;
          state_s = ST_WB;
          if (opc_r == OP_MUL) begin
            rf_w15_s = alu_res_hi;
            rf_dst_s = DST_W1_15;
          end else begin
            rf_dst_s = DST_W1;
          end
        end else if (tmo_expired_s) begin
          // abandon the instruction: no write, flag the error
          done_s  = 1'b1;
          err_s   = 1'b1;
          state_s = ST_WB;
        end else begin
          state_s = ST_EXEC;
        end
      end

      ST_WB: begin
        state_s = ST_IDLE;
      end

      default: begin
        state_s = ST_IDLE;
      end
    endcase

    instr_ready_s = (state_s == ST_IDLE);
    busy_s        = (state_s != ST_IDLE);
  end

  // State and registered outputs
  always_ff @(posedge CLOCK or negedge CLEAR) begin
    if (!CLEAR) begin
      state_r       <= ST_IDLE;
      opc_r         <= 4'd0;
      func_r        <= 4'd0;
      instr_ready_r <= 1'b1;
      rf_add1_r     <= '0;
      rf_add2_r     <= '0;
      rf_w1_r       <= '0;
      rf_w2_r       <= '0;
      rf_w15_r      <= '0;
      rf_dst_r      <= DST_NONE;
      alu_a_r       <= '0;
      alu_b_r       <= '0;
      alu_func_r    <= 4'd0;
      alu_mul_r     <= 1'b0;
      alu_start_r   <= 1'b0;
      done_r        <= 1'b0;
      err_r         <= 1'b0;
      busy_r        <= 1'b0;
    end else begin
      state_r       <= state_s;
      opc_r         <= opc_s;
      func_r        <= func_s;
      instr_ready_r <= instr_ready_s;
      rf_add1_r     <= rf_add1_s;
      rf_add2_r     <= rf_add2_s;
      rf_w1_r       <= rf_w1_s;
      rf_w2_r       <= rf_w2_s;
      rf_w15_r      <= rf_w15_s;
      rf_dst_r      <= rf_dst_s;
      alu_a_r       <= alu_a_s;
      alu_b_r       <= alu_b_s;
      alu_func_r    <= alu_func_s;
      alu_mul_r     <= alu_mul_s;
      alu_start_r   <= alu_start_s;
      done_r        <= done_s;
      err_r         <= err_s;
      busy_r        <= busy_s;
    end
  end

  assign instr_ready = instr_ready_r;
  assign rf_add1     = rf_add1_r;
  assign rf_add2     = rf_add2_r;
  assign rf_w1       = rf_w1_r;
  assign rf_w2       = rf_w2_r;
  assign rf_w15      = rf_w15_r;
  assign rf_dst      = rf_dst_r;
  assign alu_a       = alu_a_r;
  assign alu_b       = alu_b_r;
  assign alu_func    = alu_func_r;
  assign alu_mul     = alu_mul_r;
  assign alu_start   = alu_start_r;
  assign done        = done_r;
  assign err         = err_r;
  assign busy        = busy_r;

endmodule

// File: tb/tb_regfile_seq_ctrl.sv
// Directed testbench for regfile_seq_ctrl. A behavioural register-file
// array supplies rf_dat1/rf_dat2; ALU responses are driven by hand.
// Inputs change on the falling edge; outputs are sampled on the falling edge.
module tb_regfile_seq_ctrl;

  localparam int TMO = 15;

  logic        CLOCK;
  logic        CLEAR;
  logic [15:0] instr;
  logic        instr_valid;
  logic        instr_ready;
  logic [3:0]  rf_add1, rf_add2;
  logic [15:0] rf_dat1, rf_dat2;
  logic [15:0] rf_w1, rf_w2, rf_w15;
  logic [1:0]  rf_dst;
  logic [15:0] alu_a, alu_b;
  logic [3:0]  alu_func;
  logic        alu_mul, alu_start;
  logic [15:0] alu_res, alu_res_hi;
  logic        alu_done;
  logic        done, err, busy;

  logic [15:0] rf_mem [16];
  int          n_checks;
  int          n_errors;

  assign rf_dat1 = rf_mem[rf_add1];
  assign rf_dat2 = rf_mem[rf_add2];

  regfile_seq_ctrl #(
    .DATA_W      (16),
    .ADDR_W      (4),
    .ALU_TIMEOUT (TMO)
  ) dut (
    .CLOCK       (CLOCK),
    .CLEAR       (CLEAR),
    .instr       (instr),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .rf_add1     (rf_add1),
    .rf_add2     (rf_add2),
    .rf_dat1     (rf_dat1),
    .rf_dat2     (rf_dat2),
    .rf_w1       (rf_w1),
    .rf_w2       (rf_w2),
    .rf_w15      (rf_w15),
    .rf_dst      (rf_dst),
    .alu_a       (alu_a),
    .alu_b       (alu_b),
    .alu_func    (alu_func),
    .alu_mul     (alu_mul),
    .alu_start   (alu_start),
    .alu_res     (alu_res),
    .alu_res_hi  (alu_res_hi),
    .alu_done    (alu_done),
    .done        (done),
    .err         (err),
    .busy        (busy)
  );

  // 100 MHz clock
  initial begin
    CLOCK = 1'b0;
    forever #5 CLOCK = ~CLOCK;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Present one instruction at a falling edge; returns in the READ cycle
  task automatic send(input logic [15:0] ins);
    int w;
    w = 0;
    while (!instr_ready && w < 50) begin
      @(negedge CLOCK);
      w++;
    end
    chk("ready_before_send", instr_ready, 1'b1);
    instr       = ins;
    instr_valid = 1'b1;
    @(posedge CLOCK);
    @(negedge CLOCK);
    instr_valid = 1'b0;
    instr       = 16'h0000;
  endtask

  initial begin
    int  k;
    logic bad;
    n_checks    = 0;
    n_errors    = 0;
    CLEAR       = 1'b0;
    instr       = 16'h0000;
    instr_valid = 1'b0;
    alu_res     = 16'h0000;
    alu_res_hi  = 16'h0000;
    alu_done    = 1'b0;
    for (int i = 0; i < 16; i++) rf_mem[i] = 16'h0000;

    // ---- reset state ----
    #10;
    chk("rst_dst",   rf_dst, 2'b00);
    chk("rst_busy",  busy, 1'b0);
    chk("rst_ready", instr_ready, 1'b1);
    chk("rst_data",  {rf_w1, rf_w2}, 32'h0000_0000);
    chk("rst_alu",   {alu_a, alu_b}, 32'h0000_0000);
    chk("rst_misc",  {rf_w15, rf_add1, rf_add2, alu_start, done, err}, 32'h0000_0000);
    @(negedge CLOCK);
    CLEAR = 1'b1;
    @(negedge CLOCK);

    // ---- ALU add, done in the same cycle as start ----
    rf_mem[1] = 16'h0003;
    rf_mem[2] = 16'h0004;
    send(16'h0120);                              // cycle N+1: READ
    chk("alu_read_ready", instr_ready, 1'b0);
    chk("alu_read_busy",  busy, 1'b1);
    @(negedge CLOCK);                            // N+2: EXEC
    chk("alu_start", alu_start, 1'b1);
    chk("alu_ops",   {alu_a, alu_b}, 32'h0003_0004);
    chk("alu_fm",    {alu_func, alu_mul}, 5'b0000_0);
    alu_res  = 16'h0007;
    alu_done = 1'b1;
    @(negedge CLOCK);                            // N+3: WB
    alu_done = 1'b0;
    chk("alu_dst",  rf_dst, 2'b01);
    chk("alu_w1",   rf_w1, 16'h0007);
    chk("alu_add1", rf_add1, 4'd1);
    chk("alu_done", {done, err}, 2'b10);
    @(negedge CLOCK);                            // N+4: IDLE
    chk("alu_ready_back", instr_ready, 1'b1);
    chk("alu_post", {rf_dst, done}, 3'b000);

    // ---- MUL, done after 4 EXEC cycles ----
    rf_mem[3] = 16'h1234;
    rf_mem[4] = 16'h0100;
    send(16'h1340);
    @(negedge CLOCK);                            // EXEC 1
    chk("mul_start", {alu_start, alu_mul}, 2'b11);
    chk("mul_ops",   {alu_a, alu_b}, 32'h1234_0100);
    @(negedge CLOCK);                            // EXEC 2
    chk("mul_start_pulse", alu_start, 1'b0);
    chk("mul_exec_dst", rf_dst, 2'b00);
    @(negedge CLOCK);                            // EXEC 3
    @(negedge CLOCK);                            // EXEC 4
    alu_res    = 16'h3400;
    alu_res_hi = 16'h0012;
    alu_done   = 1'b1;
    @(negedge CLOCK);                            // WB
    alu_done = 1'b0;
    chk("mul_dst", rf_dst, 2'b11);
    chk("mul_w",   {rf_w1, rf_w15}, 32'h3400_0012);
    chk("mul_done", {done, err}, 2'b10);
    @(negedge CLOCK);
    chk("mul_single_done", {done, rf_dst}, 3'b000);
    chk("mul_ready_back", instr_ready, 1'b1);

    // ---- SWAP: WB at N+2, no ALU launch ----
    rf_mem[5] = 16'hAAAA;
    rf_mem[6] = 16'h5555;
    send(16'h2560);                              // N+1: READ
    chk("swap_read_start", alu_start, 1'b0);
    @(negedge CLOCK);                            // N+2: WB
    chk("swap_dst",  rf_dst, 2'b10);
    chk("swap_w",    {rf_w1, rf_w2}, 32'h5555_AAAA);
    chk("swap_addr", {rf_add1, rf_add2}, 8'h56);
    chk("swap_flags", {done, err, alu_start}, 3'b100);
    @(negedge CLOCK);                            // N+3
    chk("swap_ready_back", instr_ready, 1'b1);

    // ---- SWAP with ra == rb ----
    send(16'h2550);
    @(negedge CLOCK);
    chk("swap_same", {rf_dst, rf_w1, rf_w2}, {2'b10, 16'hAAAA, 16'hAAAA});

    // ---- NOP ----
    send(16'h3000);
    @(negedge CLOCK);
    chk("nop", {rf_dst, done, err}, 4'b0010);

    // ---- illegal opcode ----
    send(16'hF000);
    @(negedge CLOCK);                            // N+2
    chk("ill", {rf_dst, done, err}, 4'b0011);
    @(negedge CLOCK);
    chk("ill_err_pulse", err, 1'b0);

    // ---- MUL timeout ----
    send(16'h1340);
    @(negedge CLOCK);                            // EXEC 1
    k   = 0;
    bad = 1'b0;
    while (!done && k < 40) begin
      if (rf_dst != 2'b00) bad = 1'b1;
      @(negedge CLOCK);
      k++;
    end
    chk("tmo_cycles", k, TMO);
    chk("tmo_wb", {rf_dst, done, err}, 4'b0011);
    chk("tmo_no_early_write", bad, 1'b0);
    @(negedge CLOCK);
    chk("tmo_ready_back", instr_ready, 1'b1);

    // ---- reset in the middle of EXEC ----
    send(16'h1340);
    @(negedge CLOCK);                            // EXEC 1
    @(negedge CLOCK);                            // EXEC 2
    CLEAR = 1'b0;
    #1;
    chk("mid_rst_state", {busy, instr_ready, rf_dst, done}, 5'b01000);
    chk("mid_rst_data",  {alu_a, rf_add1, alu_mul}, 21'h0);
    @(negedge CLOCK);
    CLEAR      = 1'b1;
    alu_res    = 16'hFFFF;
    alu_res_hi = 16'hFFFF;
    alu_done   = 1'b1;
    bad = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge CLOCK);
      if (rf_dst != 2'b00 || done || busy) bad = 1'b1;
    end
    alu_done = 1'b0;
    chk("late_done_ignored", bad, 1'b0);

    // ---- normal instruction after reset ----
    rf_mem[7] = 16'h0010;
    rf_mem[8] = 16'h0003;
    send(16'h0781);
    @(negedge CLOCK);                            // EXEC 1
    chk("post_func", alu_func, 4'h1);
    chk("post_ops",  {alu_a, alu_b}, 32'h0010_0003);
    alu_res  = 16'h000D;
    alu_done = 1'b1;
    @(negedge CLOCK);
    alu_done = 1'b0;
    chk("post_wb", {rf_dst, rf_add1, rf_w1, done, err}, {2'b01, 4'd7, 16'h000D, 2'b10});

    @(negedge CLOCK);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/regfile_seq_ctrl.md
Name: regfile_seq_ctrl

Overview:
- Multi-cycle sequencer between the instruction source and the 16x16 register file plus ALU.
- Accepts one 16-bit instruction per valid/ready handshake and drives the register-file read addresses.
- Captures the operands, launches the ALU, then issues exactly one write-back command per instruction.
- Owns the register-file dst/write-data ports; no other block drives them.

Parameters:
- DATA_W, 16, register and data width
- ADDR_W, 4, register address width (16 registers; R15 = hi-result register)
- ALU_TIMEOUT, 15, max EXEC cycles waiting for alu_done before abort (>=1)

Ports:
- CLOCK  in  1  single clock, rising edge
- CLEAR  in  1  asynchronous, active-low reset
- instr  in  16  instruction: [15:12] opcode, [11:8] ra, [7:4] rb, [3:0] func
- instr_valid  in  1  instruction present
- instr_ready  out  1  controller can accept
- rf_add1  out  ADDR_W  register-file read/write address 1
- rf_add2  out  ADDR_W  register-file read/write address 2
- rf_dat1  in  DATA_W  R[rf_add1], combinational from register file
- rf_dat2  in  DATA_W  R[rf_add2], combinational from register file
- rf_w1  out  DATA_W  write data for R[rf_add1]
- rf_w2  out  DATA_W  write data for R[rf_add2]
- rf_w15  out  DATA_W  write data for R15
- rf_dst  out  2  write command (encoding below)
- alu_a  out  DATA_W  operand A
- alu_b  out  DATA_W  operand B
- alu_func  out  4  ALU function
- alu_mul  out  1  request multiply
- alu_start  out  1  one-cycle launch pulse
- alu_res  in  DATA_W  result / low product
- alu_res_hi  in  DATA_W  high product
- alu_done  in  1  result valid; may be asserted in the same cycle as alu_start
- done  out  1  one-cycle pulse in the write-back cycle
- err  out  1  one-cycle pulse with done on an illegal opcode or ALU timeout
- busy  out  1  high whenever not in IDLE

Behaviour:
- rf_dst encoding:
  - 00: no write.
  - 01: rf_w1 -> R[rf_add1].
  - 10: rf_w1 -> R[rf_add1] and rf_w2 -> R[rf_add2].
  - 11: rf_w1 -> R[rf_add1] and rf_w15 -> R15.
- Opcodes:
  - 0 ALU: R[ra] <= alu(R[ra], R[rb], func); dst 01.
  - 1 MUL: R[ra] <= lo, R15 <= hi; dst 11.
  - 2 SWAP: exchange R[ra] and R[rb]; dst 10; no ALU.
  - 3 NOP: dst 00.
  - 4-15 illegal: dst 00, err.
- FSM states IDLE, READ, EXEC, WB; all outputs registered.
  - IDLE: instr_ready=1. On instr_valid, latch the instruction, load rf_add1=ra and rf_add2=rb, go to READ.
  - READ: capture rf_dat1/rf_dat2 into alu_a/alu_b.
    - ALU/MUL -> EXEC, pulse alu_start on the first EXEC cycle.
    - SWAP: rf_w1=dat2, rf_w2=dat1 -> WB.
    - NOP/illegal -> WB.
  - EXEC: a cycle counter starts at 1.
    - On alu_done, latch rf_w1=alu_res and rf_w15=alu_res_hi (MUL only), then go to WB.
    - If the counter reaches ALU_TIMEOUT without alu_done -> WB with dst 00 and err.
    - alu_done outside EXEC is ignored.
  - WB: drive rf_dst for exactly one cycle, pulse done (and err if flagged), then IDLE.
- Latency: handshake at edge N; WB (dst, done) in cycle N+3 for a single-cycle ALU op, N+2 for SWAP/NOP/illegal; instr_ready high again at N+4 / N+3.
- rf_dst is 00 in every state other than WB.
- rf_add1/rf_add2 hold their values until the next accept.
- ra==rb SWAP: legal, writes the unchanged value.
- ra or rb = 15 for ALU: legal; a MUL with ra=15 leaves R15 content defined by the register-file port priority (not this block's concern).
- Reset (CLEAR low, any time, asynchronous):
  - State goes to IDLE; every output 0 except instr_ready=1.
  - The in-flight instruction is discarded; no write is issued.
  - An ALU result arriving after reset is ignored.

Decomposition:
- Shared package regfile_pkg:
  - Opcode constants, rf_dst codes (DST_NONE/DST_W1/DST_W12/DST_W1_15) and the FSM state typedef.
  - Instruction field slice positions.
- One sub-module: regfile_seq_timeout (EXEC cycle counter with clear/enable and expired flag).
- Decode stays inline.

Test Plan:
- Reset: hold CLEAR low 10 ns -> rf_dst=00, busy=0, instr_ready=1, all data outputs 0000.
- ALU: R1=0003, R2=0004, instr=0x0120 (func 0), ALU adds with alu_done same cycle -> WB at N+3 with rf_add1=1, rf_w1=0007, rf_dst=01, done=1, err=0.
- MUL: instr=0x1340, R3=1234, R4=0100, alu_done after 4 cycles with alu_res=3400, alu_res_hi=0012 -> rf_dst=11, rf_w1=3400, rf_w15=0012, single done pulse.
- SWAP: instr=0x2560, R5=AAAA, R6=5555 -> WB at N+2: rf_dst=10, rf_w1=5555, rf_w2=AAAA, no alu_start.
- Timeout and illegal:
  - MUL with alu_done never asserted -> WB exactly ALU_TIMEOUT cycles into EXEC, rf_dst=00, done=err=1.
  - instr=0xF000 -> rf_dst=00, err=1 at N+2.
- Reset mid-EXEC: CLEAR low during a MUL -> immediate IDLE, rf_dst never nonzero; a later alu_done is ignored; the next instruction completes normally.
